cu_seq: RTL and testbench

//  Sequenced, parametrised control unit for the decode stage. Decodes the opcode into registered

---
 rtl/cu_seq_if.sv | 42 ++++
 rtl/cu_seq.sv | 258 +++++++++++++++++++++++++
 tb/tb_cu_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cu_seq_if.sv
// Decode-stage bus between the decode slot and the sequenced control unit cu_seq.
// The master drives the decode slot and interrupt inputs; the slave (cu_seq) drives the control word.
interface cu_seq_if #(
  parameter int OPC_W = 4,
  parameter int WS_W  = 2
);
  logic             valid_i;
  logic [OPC_W-1:0] opcode_i;
  logic             irq_i;
  logic             flush_i;
  logic             reg_write_o;
  logic             mem_read_o;
  logic             mem_write_o;
  logic             mem_to_reg_o;
  logic             alu_src_o;
  logic             branch_o;
  logic             out_o;
  logic             in_o;
  logic             sp_en_o;
  logic             sp_pop_o;
  logic [1:0]       push_sel_o;
  logic [WS_W-1:0]  word_sel_o;
  logic             load_pc_o;
  logic             load_flg_o;
  logic             load_vec_o;
  logic             illegal_o;
  logic             stall_o;

  modport master (
    output valid_i, opcode_i, irq_i, flush_i,
    input  reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, alu_src_o, branch_o,
           out_o, in_o, sp_en_o, sp_pop_o, push_sel_o, word_sel_o,
           load_pc_o, load_flg_o, load_vec_o, illegal_o, stall_o
  );

  modport slave (
    input  valid_i, opcode_i, irq_i, flush_i,
    output reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, alu_src_o, branch_o,
           out_o, in_o, sp_en_o, sp_pop_o, push_sel_o, word_sel_o,
           load_pc_o, load_flg_o, load_vec_o, illegal_o, stall_o
  );
endinterface

// File: rtl/cu_seq.sv
// Sequenced decode control unit: registered control word, CALL/RET/RETI/IRQ stack micro-op expansion.
// Define CU_SEQ_FLAGS_EN to add the flags push (interrupt) and flags pop (RETI) phases.
module cu_seq #(
  parameter int OPC_W  = 4,
  parameter int PC_W   = 32,
  parameter int DATA_W = 16
) (
  input  logic   clk,
  input  logic   rst,
  cu_seq_if.slave bus
);
  localparam int NW = PC_W / DATA_W;
  localparam int CW = $clog2(NW) + 1;
  localparam logic [CW-1:0] LAST = CW'(NW - 1);

  // State names the phase issued at the next edge; the first phase of a sequence is issued from IDLE.
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PUSH_PC  = 3'd1;
  localparam logic [2:0] S_POP_PC   = 3'd3;
  localparam logic [2:0] S_VEC      = 3'd4;
`ifdef CU_SEQ_FLAGS_EN
  localparam logic [2:0] S_PUSH_FLG = 3'd2;
  localparam logic [2:0] S_AFTER_PC = S_PUSH_FLG;
`else
  localparam logic [2:0] S_AFTER_PC = S_VEC;
`endif

  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(4'b0000);
  localparam logic [OPC_W-1:0] OP_SETC = OPC_W'(4'b0001);
  localparam logic [OPC_W-1:0] OP_ALU  = OPC_W'(4'b0010);
  localparam logic [OPC_W-1:0] OP_OUT  = OPC_W'(4'b0011);
  localparam logic [OPC_W-1:0] OP_IN   = OPC_W'(4'b0100);
  localparam logic [OPC_W-1:0] OP_SHL  = OPC_W'(4'b0101);
  localparam logic [OPC_W-1:0] OP_PUSH = OPC_W'(4'b0110);
  localparam logic [OPC_W-1:0] OP_POP  = OPC_W'(4'b0111);
  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(4'b1000);
  localparam logic [OPC_W-1:0] OP_CALL = OPC_W'(4'b1001);
  localparam logic [OPC_W-1:0] OP_RET  = OPC_W'(4'b1010);
  localparam logic [OPC_W-1:0] OP_LDD  = OPC_W'(4'b1011);
  localparam logic [OPC_W-1:0] OP_STD  = OPC_W'(4'b1100);
  localparam logic [OPC_W-1:0] OP_RETI = OPC_W'(4'b1110);

  typedef struct packed {
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          alu_src;
    logic          branch;
    logic          out;
    logic          inp;
    logic          sp_en;
    logic          sp_pop;
    logic [1:0]    push_sel;
    logic [CW-1:0] word_sel;
    logic          load_pc;
    logic          load_flg;
    logic          load_vec;
    logic          illegal;
  } ctrl_t;

  ctrl_t         ctrl_d, ctrl_q;
  logic [2:0]    state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          irq_pend_d, irq_pend_q;
  logic          irq_seq_d, irq_seq_q;
  logic          accept_s, irq_take_s, stall_s;

  function automatic ctrl_t push_w(input logic [CW-1:0] idx, input logic [1:0] sel);
    ctrl_t c;
    c           = '0;
    c.mem_write = 1'b1;
    c.sp_en     = 1'b1;
    c.push_sel  = sel;
    c.word_sel  = idx;
    return c;
  endfunction

  function automatic ctrl_t pop_w(input logic [CW-1:0] idx);
    ctrl_t c;
    c          = '0;
    c.mem_read = 1'b1;
    c.sp_en    = 1'b1;
    c.sp_pop   = 1'b1;
    c.word_sel = idx;
    return c;
  endfunction

  function automatic ctrl_t decode(input logic [OPC_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_NOP, OP_SETC, OP_CALL, OP_RET, OP_RETI: c = '0;
      OP_ALU:  c.reg_write = 1'b1;
      OP_OUT:  c.out = 1'b1;
      OP_IN:   begin c.inp = 1'b1; c.reg_write = 1'b1; end
      OP_SHL:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; end
      OP_PUSH: begin c.mem_write = 1'b1; c.sp_en = 1'b1; end
      OP_POP:  begin
        c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
        c.sp_en = 1'b1; c.sp_pop = 1'b1;
      end
      OP_JMP:  c.branch = 1'b1;
      OP_LDD:  begin c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      OP_STD:  c.mem_write = 1'b1;
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  assign accept_s   = bus.valid_i & ~bus.flush_i;
  assign irq_take_s = (state_q == S_IDLE) & (bus.irq_i | irq_pend_q);

  // Next-state, next control word and interrupt bookkeeping.
  always_comb begin
    ctrl_d     = '0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    irq_seq_d  = irq_seq_q;
    irq_pend_d = irq_pend_q;
    stall_s    = 1'b1;
    case (state_q)
      S_IDLE: begin
        stall_s = 1'b0;
        if (irq_take_s) begin
          stall_s    = 1'b1;
          irq_pend_d = 1'b0;
          irq_seq_d  = 1'b1;
          ctrl_d     = push_w(LAST, 2'd1);
          if (NW == 1) begin
            state_d = S_AFTER_PC;
          end else begin
            state_d = S_PUSH_PC;
            cnt_d   = CW'(1);
          end
        end else if (accept_s) begin
          case (bus.opcode_i)
            OP_CALL: begin
              stall_s   = 1'b1;
              irq_seq_d = 1'b0;
              ctrl_d    = push_w(LAST, 2'd1);
              if (NW == 1) begin
                ctrl_d.branch = 1'b1;
              end else begin
                state_d = S_PUSH_PC;
                cnt_d   = CW'(1);
              end
            end
`ifdef CU_SEQ_FLAGS_EN
            OP_RETI: begin
              stall_s         = 1'b1;
              ctrl_d          = pop_w('0);
              ctrl_d.load_flg = 1'b1;
              state_d         = S_POP_PC;
              cnt_d           = '0;
            end
            OP_RET: begin
`else
            OP_RET, OP_RETI: begin
`endif
              stall_s = 1'b1;
              ctrl_d  = pop_w('0);
              if (NW == 1) begin
                ctrl_d.load_pc = 1'b1;
              end else begin
                state_d = S_POP_PC;
                cnt_d   = CW'(1);
              end
            end
            default: ctrl_d = decode(bus.opcode_i);
          endcase
        end else begin
          ctrl_d = '0;
        end
      end
      S_PUSH_PC: begin
        ctrl_d = push_w(LAST - cnt_q, 2'd1);
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (irq_seq_q) begin
            state_d = S_AFTER_PC;
          end else begin
            ctrl_d.branch = 1'b1;
            state_d       = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_POP_PC: begin
        ctrl_d = pop_w(cnt_q);
        if (cnt_q == LAST) begin
          ctrl_d.load_pc = 1'b1;
          cnt_d          = '0;
          state_d        = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef CU_SEQ_FLAGS_EN
      S_PUSH_FLG: begin
        ctrl_d  = push_w('0, 2'd2);
        state_d = S_VEC;
      end
`endif
      S_VEC: begin
        ctrl_d.load_vec = 1'b1;
        irq_seq_d       = 1'b0;
        state_d         = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // A request arriving mid-sequence waits for IDLE; sequences never nest.
    if (state_q != S_IDLE) begin
      irq_pend_d = irq_pend_q | bus.irq_i;
    end else begin
      irq_pend_d = irq_pend_d;
    end
  end

  // State and registered control word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      irq_pend_q <= 1'b0;
      irq_seq_q  <= 1'b0;
      ctrl_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      irq_pend_q <= irq_pend_d;
      irq_seq_q  <= irq_seq_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign bus.reg_write_o  = ctrl_q.reg_write;
  assign bus.mem_read_o   = ctrl_q.mem_read;
  assign bus.mem_write_o  = ctrl_q.mem_write;
  assign bus.mem_to_reg_o = ctrl_q.mem_to_reg;
  assign bus.alu_src_o    = ctrl_q.alu_src;
  assign bus.branch_o     = ctrl_q.branch;
  assign bus.out_o        = ctrl_q.out;
  assign bus.in_o         = ctrl_q.inp;
  assign bus.sp_en_o      = ctrl_q.sp_en;
  assign bus.sp_pop_o     = ctrl_q.sp_pop;
  assign bus.push_sel_o   = ctrl_q.push_sel;
  assign bus.word_sel_o   = ctrl_q.word_sel;
  assign bus.load_pc_o    = ctrl_q.load_pc;
  assign bus.load_flg_o   = ctrl_q.load_flg;
  assign bus.load_vec_o   = ctrl_q.load_vec;
  assign bus.illegal_o    = ctrl_q.illegal;
  assign bus.stall_o      = stall_s & ~rst;
endmodule

// File: tb/tb_cu_seq.sv
// Directed bench for cu_seq (PC_W=32, DATA_W=16, so two stack words per PC).
module tb_cu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  cu_seq_if #(.OPC_W(4), .WS_W(2)) bus ();

  cu_seq #(.OPC_W(4), .PC_W(32), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Expected-control bit masks; layout matches ctrl_obs below.
  localparam logic [17:0] RW  = 18'h20000, MR  = 18'h10000, MW   = 18'h08000, M2R = 18'h04000;
  localparam logic [17:0] AS  = 18'h02000, BR  = 18'h01000, OUTB = 18'h00800, INB = 18'h00400;
  localparam logic [17:0] SPE = 18'h00200, POPB = 18'h00100, PS1 = 18'h00040, PS2 = 18'h00080;
  localparam logic [17:0] WS1 = 18'h00010, LPC = 18'h00008, LFL = 18'h00004, LVC = 18'h00002;
  localparam logic [17:0] ILL = 18'h00001, ZERO = 18'h00000;
  localparam logic [17:0] PUSHW = MW | SPE | PS1;
  localparam logic [17:0] POPW  = MR | SPE | POPB;

  logic [17:0] ctrl_obs;
  assign ctrl_obs = {bus.reg_write_o, bus.mem_read_o, bus.mem_write_o, bus.mem_to_reg_o,
                     bus.alu_src_o, bus.branch_o, bus.out_o, bus.in_o, bus.sp_en_o, bus.sp_pop_o,
                     bus.push_sel_o, bus.word_sel_o, bus.load_pc_o, bus.load_flg_o,
                     bus.load_vec_o, bus.illegal_o};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the current cycle's control word and stall mid-cycle, then advance one cycle.
  task automatic cyc(input string tag, input logic [17:0] exp_ctrl, input logic exp_stall);
    @(negedge clk);
    check_eq({tag, ".ctrl"}, {14'd0, ctrl_obs}, {14'd0, exp_ctrl});
    check_eq({tag, ".stall"}, {31'd0, bus.stall_o}, {31'd0, exp_stall});
    tick();
  endtask

  task automatic single(input string tag, input logic [3:0] op, input logic [17:0] exp_ctrl);
    bus.valid_i  = 1'b1;
    bus.opcode_i = op;
    tick();
    bus.valid_i  = 1'b0;
    cyc(tag, exp_ctrl, 1'b0);
  endtask

  initial begin
    bus.valid_i  = 1'b1;
    bus.opcode_i = 4'b0010;
    bus.irq_i    = 1'b0;
    bus.flush_i  = 1'b0;
    tick();
    cyc("rst_a", ZERO, 1'b0);
    cyc("rst_b", ZERO, 1'b0);
    rst = 1'b0;
    cyc("rst_rel", ZERO, 1'b0);
    bus.valid_i = 1'b0;
    cyc("alu_first", RW, 1'b0);

    single("op_nop",  4'b0000, ZERO);
    single("op_setc", 4'b0001, ZERO);
    single("op_out",  4'b0011, OUTB);
    single("op_in",   4'b0100, INB | RW);
    single("op_shl",  4'b0101, AS | RW);
    single("op_push", 4'b0110, MW | SPE);
    single("op_pop",  4'b0111, MR | M2R | RW | SPE | POPB);
    single("op_jmp",  4'b1000, BR);
    single("op_ldd",  4'b1011, MR | M2R | RW);
    single("op_std",  4'b1100, MW);
    single("op_1101", 4'b1101, ILL);
    single("op_1111", 4'b1111, ILL);
    cyc("ill_once", ZERO, 1'b0);

    bus.opcode_i = 4'b1111;
    cyc("novalid", ZERO, 1'b0);
    cyc("novalid2", ZERO, 1'b0);

    bus.valid_i = 1'b1; bus.opcode_i = 4'b0010; bus.flush_i = 1'b1;
    tick();
    bus.valid_i = 1'b0; bus.flush_i = 1'b0;
    cyc("flush", ZERO, 1'b0);

    // CALL; flush during the sequence is ignored
    bus.valid_i = 1'b1; bus.opcode_i = 4'b1001;
    cyc("call0", ZERO, 1'b1);
    bus.valid_i = 1'b0; bus.flush_i = 1'b1;
    cyc("call1", PUSHW | WS1, 1'b1);
    bus.flush_i = 1'b0;
    cyc("call2", PUSHW | BR, 1'b0);
    cyc("call3", ZERO, 1'b0);

    // irq pulse during CALL cycle 1 is held pending and taken afterwards
    bus.valid_i = 1'b1; bus.opcode_i = 4'b1001;
    cyc("ci0", ZERO, 1'b1);
    bus.valid_i = 1'b0; bus.irq_i = 1'b1;
    cyc("ci1", PUSHW | WS1, 1'b1);
    bus.irq_i = 1'b0;
    cyc("ci2", PUSHW | BR, 1'b1);
    cyc("ci3", PUSHW | WS1, 1'b1);
`ifdef CU_SEQ_FLAGS_EN
    cyc("ci4", PUSHW, 1'b1);
    cyc("ci5", MW | SPE | PS2, 1'b1);
    cyc("ci6", LVC, 1'b0);
`else
    cyc("ci4", PUSHW, 1'b1);
    cyc("ci5", LVC, 1'b0);
`endif
    cyc("ci_end", ZERO, 1'b0);

    // RET
    bus.valid_i = 1'b1; bus.opcode_i = 4'b1010;
    cyc("ret0", ZERO, 1'b1);
    bus.valid_i = 1'b0;
    cyc("ret1", POPW, 1'b1);
    cyc("ret2", POPW | WS1 | LPC, 1'b0);
    cyc("ret3", ZERO, 1'b0);

    // RETI
    bus.valid_i = 1'b1; bus.opcode_i = 4'b1110;
    cyc("reti0", ZERO, 1'b1);
    bus.valid_i = 1'b0;
`ifdef CU_SEQ_FLAGS_EN
    cyc("reti1", POPW | LFL, 1'b1);
    cyc("reti2", POPW, 1'b1);
    cyc("reti3", POPW | WS1 | LPC, 1'b0);
`else
    cyc("reti1", POPW, 1'b1);
    cyc("reti2", POPW | WS1 | LPC, 1'b0);
`endif
    cyc("reti_end", ZERO, 1'b0);

    // reset during RET cycle 1, with an irq that must not survive the reset
    bus.valid_i = 1'b1; bus.opcode_i = 4'b1010;
    cyc("rr0", ZERO, 1'b1);
    bus.valid_i = 1'b0; rst = 1'b1; bus.irq_i = 1'b1;
    cyc("rr1", POPW, 1'b0);
    rst = 1'b0; bus.irq_i = 1'b0;
    cyc("rr2", ZERO, 1'b0);
    cyc("rr3", ZERO, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
